dilithium_rej_sampler: RTL and testbench

//  Downstream of keccak_top. Consumes its 64-bit SHAKE128 squeeze words (dst_write/dout)
//  and runs Dilithium uniform rejection sampling (RejNTTPoly): 3 bytes -> 23-bit candidate.
//  A candidate is kept only if it is < Q. Accepted coefficients stream out to the NTT/poly RAM.

---
 rtl/dilithium_rej_sampler_pkg.sv | 23 ++
 rtl/dilithium_rej_sampler_if.sv | 31 +++
 rtl/dilithium_rej_sampler_byte_buffer.sv | 48 ++++
 rtl/dilithium_rej_sampler.sv | 115 +++++++++++
 tb/tb_dilithium_rej_sampler.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_rej_sampler_pkg.sv
// ============================================================================
// Module : dilithium_rej_sampler_pkg
// Brief  : Shared constants and FSM encoding for the Dilithium rejection sampler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dilithium_rej_sampler_pkg;

    localparam int             c_cw     = 23;
    localparam logic [c_cw-1:0] c_q      = 23'd8380417;
    localparam logic [8:0]      c_n      = 9'd256;
    localparam logic [8:0]      c_n_last = 9'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dilithium_rej_sampler_if.sv
// ============================================================================
// Module : dilithium_rej_sampler_if
// Brief  : Squeeze-word input stream and coefficient output stream bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dilithium_rej_sampler_if;

    logic                                      in_write;
    logic [63:0]                               in_data;
    logic                                      in_ready;
    logic                                      coef_valid;
    logic                                      coef_ready;
    logic [dilithium_rej_sampler_pkg::c_cw-1:0] coef_data;
    logic [7:0]                                coef_idx;
    logic                                      coef_last;

    modport master (
        output in_write, in_data, coef_ready,
        input  in_ready, coef_valid, coef_data, coef_idx, coef_last
    );

    modport slave (
        input  in_write, in_data, coef_ready,
        output in_ready, coef_valid, coef_data, coef_idx, coef_last
    );

endinterface

`default_nettype wire

// File: rtl/dilithium_rej_sampler_byte_buffer.sv
// ============================================================================
// Module : dilithium_rej_sampler_byte_buffer
// Brief  : 10-byte little-endian append/shift buffer feeding 3-byte candidates.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dilithium_rej_sampler_byte_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [63:0] i_data,
    input  logic        i_pop3,
    output logic [3:0]  o_cnt,
    output logic [22:0] o_cand
);

    logic [79:0] r_buf;
    logic [3:0]  r_cnt;
    logic [79:0] w_shifted;

    // Bytes above r_cnt are always zero, so an OR places the new word.
    assign w_shifted = {16'd0, i_data} << {r_cnt, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_buf <= r_buf | w_shifted;
            r_cnt <= r_cnt + 4'd8;
        end else if (i_pop3) begin
            r_buf <= {24'd0, r_buf[79:24]};
            r_cnt <= r_cnt - 4'd3;
        end
    end

    assign o_cnt  = r_cnt;
    // Byte 2 bit 7 is masked off: candidates are 23 bits.
    assign o_cand = r_buf[22:0];

endmodule

`default_nettype wire

// File: rtl/dilithium_rej_sampler.sv
// ============================================================================
// Module : dilithium_rej_sampler
// Brief  : Dilithium RejNTTPoly uniform sampler over SHAKE128 squeeze words.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dilithium_rej_sampler
    import dilithium_rej_sampler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    dilithium_rej_sampler_if.slave  io
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [8:0]      r_acc;
    logic            r_done;
    logic            r_valid;
    logic            r_last;
    logic [c_cw-1:0] r_data;
    logic [7:0]      r_idx;

    logic [3:0]      w_cnt;
    logic [c_cw-1:0] w_cand;
    logic            w_run;
    logic            w_enter_run;
    logic            w_in_ready;
    logic            w_load;
    logic            w_hs;
    logic            w_last_hs;
    logic            w_extract;
    logic            w_keep;

    assign w_run       = (r_state == ST_RUN);
    assign w_enter_run = start && (r_state != ST_RUN);
    assign w_in_ready  = w_run && (w_cnt < 4'd3);
    assign w_load      = io.in_write && w_in_ready;
    assign w_hs        = r_valid && io.coef_ready;
    assign w_last_hs   = w_hs && r_last;
    // Extraction only when the output slot is free or draining this cycle.
    assign w_extract   = w_run && (w_cnt >= 4'd3) && (!r_valid || io.coef_ready)
                         && (r_acc != c_n);
    assign w_keep      = w_extract && (w_cand < c_q);

    dilithium_rej_sampler_byte_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_enter_run),
        .i_load  (w_load),
        .i_data  (io.in_data),
        .i_pop3  (w_extract),
        .o_cnt   (w_cnt),
        .o_cand  (w_cand)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)     w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last_hs) w_state_nxt = ST_DONE;
            ST_DONE: if (start)     w_state_nxt = ST_RUN;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc   <= '0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            if (w_enter_run) begin
                r_acc  <= '0;
                r_done <= 1'b0;
            end else begin
                if (w_keep)    r_acc  <= r_acc + 9'd1;
                if (w_last_hs) r_done <= 1'b1;
            end

            if (w_keep) begin
                r_valid <= 1'b1;
                r_data  <= w_cand;
                r_idx   <= r_acc[7:0];
                r_last  <= (r_acc == c_n_last);
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign io.in_ready   = w_in_ready;
    assign io.coef_valid = r_valid;
    assign io.coef_data  = r_data;
    assign io.coef_idx   = r_idx;
    assign io.coef_last  = r_last;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dilithium_rej_sampler.sv
// ============================================================================
// Module : tb_dilithium_rej_sampler
// Brief  : Directed and randomized bench against a byte-queue sampling model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dilithium_rej_sampler;

    logic clk;
    logic rst;
    logic start;
    logic done;

    dilithium_rej_sampler_if bus ();

    dilithium_rej_sampler dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .done  (done),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: raw accepted bytes and the coefficients they imply.
    byte unsigned m_bytes[$];
    int           exp_q[$];
    int           obs_d[$];
    int           obs_i[$];
    int           m_seen;
    int           m_gen;
    int           cyc = 0;
    int           last_hs_cyc;
    int           done_cyc;
    bit           done_seen;
    int           mon_c;
    int           mon_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        m_bytes.delete();
        exp_q.delete();
        obs_d.delete();
        obs_i.delete();
        m_seen      = 0;
        m_gen       = 0;
        done_seen   = 1'b0;
        last_hs_cyc = -1;
        done_cyc    = -100;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (bus.in_write && bus.in_ready)
                for (int b = 0; b < 8; b++) m_bytes.push_back(bus.in_data[8*b +: 8]);
            if (bus.coef_valid && bus.coef_ready) begin
                while (exp_q.size() == 0 && m_bytes.size() >= 3 && m_gen < 256) begin
                    mon_c = int'(m_bytes[0]) + int'(m_bytes[1]) * 256
                          + (int'(m_bytes[2]) % 128) * 65536;
                    void'(m_bytes.pop_front());
                    void'(m_bytes.pop_front());
                    void'(m_bytes.pop_front());
                    if (mon_c < 8380417) begin
                        exp_q.push_back(mon_c);
                        m_gen++;
                    end
                end
                if (exp_q.size() == 0) begin
                    chk("spurious_coef", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("coef_data", 64'(bus.coef_data), 64'(mon_e));
                    chk("coef_idx",  64'(bus.coef_idx),  64'(m_seen));
                    chk("coef_last", 64'(bus.coef_last), 64'(m_seen == 255));
                end
                obs_d.push_back(int'(bus.coef_data));
                obs_i.push_back(int'(bus.coef_idx));
                if (bus.coef_last) last_hs_cyc = cyc;
                m_seen++;
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        start          = 1'b0;
        bus.in_write   = 1'b1;
        bus.in_data    = {$urandom, $urandom};
        bus.coef_ready = 1'b1;
        model_clear();
        step();
        step();
        chk("rst_in_ready",   64'(bus.in_ready),   64'd0);
        chk("rst_coef_valid", 64'(bus.coef_valid), 64'd0);
        chk("rst_done",       64'(done),           64'd0);
        chk("rst_coef_data",  64'(bus.coef_data),  64'd0);
        chk("rst_coef_idx",   64'(bus.coef_idx),   64'd0);
        chk("rst_coef_last",  64'(bus.coef_last),  64'd0);
        rst          = 1'b1;
        bus.in_write = 1'b0;
        step();
        chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic pulse_start();
        model_clear();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w);
        int k = 0;
        while (!bus.in_ready && k < 50) begin
            step();
            k++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'd0, 64'd1);
        end else begin
            bus.in_write = 1'b1;
            bus.in_data  = w;
            step();
            bus.in_write = 1'b0;
        end
    endtask

    task automatic wait_coefs(input int n, input int budget);
        int k = 0;
        while (obs_d.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("coef_arrival", 64'(obs_d.size() >= n), 64'd1);
    endtask

    function automatic logic [63:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 3) == 0) w[8*b +: 8] = 8'hFF;
        return w;
    endfunction

    task automatic run_stream(input bit rnd, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            bus.in_write   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data    = rnd ? rand_word() : 64'd0;
            bus.coef_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            step();
            k++;
        end
        bus.in_write   = 1'b0;
        bus.coef_ready = 1'b1;
        chk("stream_done", 64'(done), 64'd1);
    endtask

    initial begin
        rst            = 1'b0;
        start          = 1'b0;
        bus.in_write   = 1'b0;
        bus.in_data    = '0;
        bus.coef_ready = 1'b1;

        do_reset();

        // Two kept candidates from one word, two zero bytes left over.
        pulse_start();
        send_word(64'h0000_0000_0003_0201);
        wait_coefs(2, 20);
        repeat (5) step();
        chk("t2_count", 64'(obs_d.size()), 64'd2);
        chk("t2_d0",    64'(obs_d[0]), 64'd197121);
        chk("t2_i0",    64'(obs_i[0]), 64'd0);
        chk("t2_d1",    64'(obs_d[1]), 64'd0);
        chk("t2_i1",    64'(obs_i[1]), 64'd1);
        chk("t2_in_ready", 64'(bus.in_ready), 64'd1);

        // Boundary candidates: 2^23-1 and Q rejected, Q-1 kept, bit 23 masked.
        do_reset();
        pulse_start();
        send_word(64'hE001_7FE0_00FF_FFFF);
        send_word(64'hFFFF_FFFF_8000_007F);
        repeat (20) step();
        chk("t3_count", 64'(obs_d.size()), 64'd2);
        chk("t3_d0",    64'(obs_d[0]), 64'd8380416);
        chk("t3_i0",    64'(obs_i[0]), 64'd0);
        chk("t3_d1",    64'(obs_d[1]), 64'd0);
        chk("t3_i1",    64'(obs_i[1]), 64'd1);

        // Candidate straddling two words.
        do_reset();
        pulse_start();
        send_word(64'h4433_2211_0A0B_0C0D);
        send_word(64'h0000_0000_0000_0055);
        repeat (20) step();
        chk("t4_count", 64'(obs_d.size()), 64'd5);
        chk("t4_d2",    64'(obs_d[2]), 64'h55_4433);
        chk("t4_i2",    64'(obs_i[2]), 64'd2);

        // Backpressure hold then release.
        do_reset();
        pulse_start();
        bus.coef_ready = 1'b0;
        send_word(64'h1122_3344_5566_7788);
        repeat (3) step();
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_valid", 64'(bus.coef_valid), 64'd1);
            chk("t5_hold_data",  64'(bus.coef_data),  64'h66_7788);
            chk("t5_hold_idx",   64'(bus.coef_idx),   64'd0);
            chk("t5_hold_ready", 64'(bus.in_ready),   64'd0);
            step();
        end
        bus.coef_ready = 1'b1;
        send_word(64'h0102_0304_0506_0708);
        wait_coefs(5, 40);
        repeat (5) step();
        chk("t5_count", 64'(obs_d.size()), 64'd5);
        chk("t5_d0",    64'(obs_d[0]), 64'h66_7788);
        chk("t5_d1",    64'(obs_d[1]), 64'h33_4455);
        chk("t5_d4",    64'(obs_d[4]), 64'h02_0304);

        // Full polynomial of zeros, then restart.
        do_reset();
        pulse_start();
        run_stream(1'b0, 3000);
        step();
        chk("t6_total",      64'(m_seen),           64'd256);
        chk("t6_done_delay", 64'(done_cyc),         64'(last_hs_cyc + 1));
        chk("t6_in_ready",   64'(bus.in_ready),     64'd0);
        chk("t6_valid",      64'(bus.coef_valid),   64'd0);
        chk("t6_done_held",  64'(done),             64'd1);
        pulse_start();
        chk("t6_done_clear", 64'(done),             64'd0);
        send_word(64'd0);
        wait_coefs(1, 20);
        chk("t6_restart_idx", 64'(obs_i[0]), 64'd0);

        // Randomized words, write strobes and backpressure.
        do_reset();
        pulse_start();
        run_stream(1'b1, 20000);
        step();
        chk("rnd_total", 64'(m_seen), 64'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
